// File: rtl/axi_bw_response_router.sv
// B-channel response router: a 2-entry in-order FIFO that steers each response to its
// issuing target port, and keeps a per-target outstanding-write counter.
module axi_bw_response_router #(
  parameter int unsigned AXI_USER_W  = 6,
  parameter int unsigned N_TARG_PORT = 7,
  parameter int unsigned AXI_ID_IN   = 16,
  parameter int unsigned AXI_ID_OUT  = AXI_ID_IN + $clog2(N_TARG_PORT),
  parameter int unsigned CNT_W       = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [AXI_ID_OUT-1:0]                    bid_i,
  input  logic [1:0]                               bresp_i,
  input  logic [AXI_USER_W-1:0]                    buser_i,
  input  logic                                     bvalid_i,
  output logic                                     bready_o,
  output logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]    bid_o,
  output logic [N_TARG_PORT-1:0][1:0]              bresp_o,
  output logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]   buser_o,
  output logic [N_TARG_PORT-1:0]                   bvalid_o,
  input  logic [N_TARG_PORT-1:0]                   bready_i,
  input  logic                                     aw_issue_i,
  input  logic [$clog2(N_TARG_PORT)-1:0]           aw_src_i,
  output logic [N_TARG_PORT-1:0]                   full_o,
  output logic [N_TARG_PORT-1:0]                   pending_o,
  output logic                                     id_err_o
);

  localparam int unsigned SEL_W = AXI_ID_OUT - AXI_ID_IN;

  typedef struct packed {
    logic [AXI_ID_OUT-1:0] id;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
  } entry_t;

  entry_t [1:0]                       mem_q, mem_d;
  logic                               wr_ptr_q, wr_ptr_d;
  logic                               rd_ptr_q, rd_ptr_d;
  logic [1:0]                         count_q, count_d;
  logic [N_TARG_PORT-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_TARG_PORT-1:0]             full_q, full_d;
  logic [N_TARG_PORT-1:0]             pending_q, pending_d;

  entry_t             head;
  logic [SEL_W-1:0]   sel;
  logic               routed;
  logic               unroutable;
  logic               push;
  logic               pop;
  logic               inc;
  logic               dec;

  assign bready_o  = (count_q != 2'd2);
  assign full_o    = full_q;
  assign pending_o = pending_q;

  always_comb begin
    head       = mem_q[rd_ptr_q];
    sel        = head.id[AXI_ID_OUT-1:AXI_ID_IN];
    routed     = (count_q != 2'd0) && (32'(sel) < N_TARG_PORT);
    unroutable = (count_q != 2'd0) && !(32'(sel) < N_TARG_PORT);
    push       = bvalid_i && bready_o;
    pop        = unroutable || (routed && bready_i[sel]);
    id_err_o   = unroutable;

    bvalid_o = '0;
    if (routed) bvalid_o[sel] = 1'b1;

    for (int unsigned t = 0; t < N_TARG_PORT; t++) begin
      bid_o[t]   = head.id[AXI_ID_IN-1:0];
      bresp_o[t] = head.resp;
      buser_o[t] = head.user;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + 2'(push) - 2'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = '{id: bid_i, resp: bresp_i, user: buser_i};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  // Discarded (unroutable) pops never decrement: dec requires a routed head.
  always_comb begin
    cnt_d     = cnt_q;
    full_d    = '0;
    pending_d = '0;
    inc       = 1'b0;
    dec       = 1'b0;
    for (int unsigned t = 0; t < N_TARG_PORT; t++) begin
      inc = aw_issue_i && (32'(aw_src_i) == t);
      dec = pop && routed && (32'(sel) == t);
      if (inc && !dec && (cnt_q[t] != '1)) cnt_d[t] = cnt_q[t] + 1'b1;
      if (dec && !inc && (cnt_q[t] != '0)) cnt_d[t] = cnt_q[t] - 1'b1;
      full_d[t]    = (cnt_d[t] == '1);
      pending_d[t] = (cnt_d[t] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= '0;
      cnt_q     <= '0;
      full_q    <= '0;
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_axi_bw_response_router.sv
// Randomized bench for axi_bw_response_router against a queue-based reference model.
module tb_axi_bw_response_router;

  localparam int N  = 7;
  localparam int IW = 16;
  localparam int OW = 19;
  localparam int UW = 6;
  localparam int CMAX = 15;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [OW-1:0]            bid_i;
  logic [1:0]               bresp_i;
  logic [UW-1:0]            buser_i;
  logic                     bvalid_i;
  logic                     bready_o;
  logic [N-1:0][IW-1:0]     bid_o;
  logic [N-1:0][1:0]        bresp_o;
  logic [N-1:0][UW-1:0]     buser_o;
  logic [N-1:0]             bvalid_o;
  logic [N-1:0]             bready_i;
  logic                     aw_issue_i;
  logic [2:0]               aw_src_i;
  logic [N-1:0]             full_o;
  logic [N-1:0]             pending_o;
  logic                     id_err_o;

  axi_bw_response_router #(
    .AXI_USER_W (UW),
    .N_TARG_PORT(N),
    .AXI_ID_IN  (IW),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bid_i     (bid_i),
    .bresp_i   (bresp_i),
    .buser_i   (buser_i),
    .bvalid_i  (bvalid_i),
    .bready_o  (bready_o),
    .bid_o     (bid_o),
    .bresp_o   (bresp_o),
    .buser_o   (buser_o),
    .bvalid_o  (bvalid_o),
    .bready_i  (bready_i),
    .aw_issue_i(aw_issue_i),
    .aw_src_i  (aw_src_i),
    .full_o    (full_o),
    .pending_o (pending_o),
    .id_err_o  (id_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] id;
    logic [1:0]    resp;
    logic [UW-1:0] user;
  } rsp_t;

  rsp_t q[$];
  int   cnt[N];
  int   vectors = 0;
  int   miscompares = 0;
  bit   last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs against the model, then advance the model across the next edge.
  task automatic step();
    logic [N-1:0] exp_v, exp_full, exp_pend;
    logic         exp_err, exp_rdy, do_pop, do_push;
    int           sel;
    rsp_t         r;
    @(negedge clk);
    exp_rdy = (q.size() != 2);
    exp_v   = '0;
    exp_err = 1'b0;
    sel     = -1;
    if (q.size() > 0) begin
      sel = int'(q[0].id[OW-1:IW]);
      if (sel < N) exp_v[sel] = 1'b1;
      else exp_err = 1'b1;
      for (int t = 0; t < N; t++)
        check($sformatf("payload%0d", t), {bid_o[t], bresp_o[t], buser_o[t]},
              {q[0].id[IW-1:0], q[0].resp, q[0].user});
    end
    for (int t = 0; t < N; t++) begin
      exp_full[t] = (cnt[t] == CMAX);
      exp_pend[t] = (cnt[t] != 0);
    end
    check("bready", bready_o, exp_rdy);
    check("bvalid", bvalid_o, exp_v);
    check("id_err", id_err_o, exp_err);
    check("full", full_o, exp_full);
    check("pending", pending_o, exp_pend);

    do_pop  = (q.size() > 0) && (sel >= N || bready_i[sel]);
    do_push = bvalid_i && exp_rdy;
    for (int t = 0; t < N; t++) begin
      bit inc, dec;
      inc = aw_issue_i && (int'(aw_src_i) == t);
      dec = do_pop && (sel == t);
      if (inc && !dec && cnt[t] < CMAX) cnt[t]++;
      if (dec && !inc && cnt[t] > 0) cnt[t]--;
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      r.id = bid_i; r.resp = bresp_i; r.user = buser_i;
      q.push_back(r);
    end
    last_acc = do_push;
    @(posedge clk);
    #1;
  endtask

  task automatic new_rsp(input int route);
    bid_i    = {3'(route), 16'($urandom)};
    bresp_i  = 2'($urandom);
    buser_i  = 6'($urandom);
    bvalid_i = 1'b1;
  endtask

  task automatic randomize_inputs();
    if (!bvalid_i || last_acc) begin
      if ($urandom_range(0, 9) < 7) new_rsp($urandom_range(0, 7));
      else bvalid_i = 1'b0;
    end
    for (int t = 0; t < N; t++) bready_i[t] = ($urandom_range(0, 9) < 6);
    aw_issue_i = $urandom_range(0, 1);
    aw_src_i   = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'($urandom_range(0, N - 1));
  endtask

  initial begin
    rst_n = 1'b0; bid_i = '0; bresp_i = '0; buser_i = '0; bvalid_i = 1'b0;
    bready_i = '0; aw_issue_i = 1'b0; aw_src_i = '0;
    foreach (cnt[t]) cnt[t] = 0;

    @(negedge clk);
    check("rst_bvalid", bvalid_o, '0);
    check("rst_bready", bready_o, 1'b1);
    check("rst_full", full_o, '0);
    check("rst_pending", pending_o, '0);
    check("rst_id_err", id_err_o, 1'b0);
    check("rst_bid", bid_o, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Saturate target 4, then drain one response to it.
    aw_issue_i = 1'b1; aw_src_i = 3'd4;
    repeat (18) step();
    aw_issue_i = 1'b0;
    bready_i = '1;
    new_rsp(4);
    step();
    bvalid_i = 1'b0;
    repeat (3) step();

    // Backpressure: three back-to-back responses with all ready low.
    bready_i = '0;
    new_rsp(2);
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_acc) new_rsp($urandom_range(0, 6));
    end
    bready_i = '1;
    repeat (4) step();
    bvalid_i = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      step();
    end

    // Fill the FIFO and reset mid-stream.
    bready_i = '0; aw_issue_i = 1'b1; aw_src_i = 3'd5;
    new_rsp(3);
    for (int i = 0; i < 4; i++) begin
      step();
      if (last_acc) new_rsp(5);
    end
    check("pre_rst_depth", bready_o, 1'b0);
    rst_n = 1'b0; bvalid_i = 1'b0; aw_issue_i = 1'b0;
    @(negedge clk);
    check("midrst_bvalid", bvalid_o, '0);
    check("midrst_pending", pending_o, '0);
    check("midrst_bready", bready_o, 1'b1);
    check("midrst_id_err", id_err_o, 1'b0);
    q.delete();
    foreach (cnt[t]) cnt[t] = 0;
    last_acc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
